// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared constants and F-function helper for the Blowfish F pipeline
package bf_pkg;

   localparam int NUM_SBOX = 4;
   localparam int BF_MAX_W = 64;

   localparam logic [1:0] SB_S0 = 2'd0;
   localparam logic [1:0] SB_S1 = 2'd1;
   localparam logic [1:0] SB_S2 = 2'd2;
   localparam logic [1:0] SB_S3 = 2'd3;

   // Operands are zero-extended to BF_MAX_W; the low DATA_W bits of the result are F modulo 2^DATA_W.
   function automatic logic [BF_MAX_W-1:0] bf_f_comb(
      input logic [BF_MAX_W-1:0] s0,
      input logic [BF_MAX_W-1:0] s1,
      input logic [BF_MAX_W-1:0] s2,
      input logic [BF_MAX_W-1:0] s3
   );
      return ((s0 + s1) ^ s2) + s3;
   endfunction

endpackage

// File: rtl/bf_sbox_ram.sv
// rtl/bf_sbox_ram.sv - one S-box: synchronous write port, registered read under enable
module bf_sbox_ram #(
   parameter int IDX_W  = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**IDX_W];

   // Contents are deliberately not reset; software loads every entry before use.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/bf_f_pipe.sv
// rtl/bf_f_pipe.sv - three-stage Blowfish F-function engine with loadable S-boxes
module bf_f_pipe
   import bf_pkg::*;
#(
   parameter  int IDX_W  = 8,
   parameter  int DATA_W = 32,
   localparam int IN_W   = 4 * IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              sb_we,
   input  logic [1:0]        sb_sel,
   input  logic [IDX_W-1:0]  sb_addr,
   input  logic [DATA_W-1:0] sb_wdata,
   output logic              pipe_empty
);

   logic                v1, v2;
   logic                stall, en1, en2, accept;
   logic [NUM_SBOX-1:0] we_vec;
   logic [DATA_W-1:0]   rd [NUM_SBOX];
   logic [DATA_W-1:0]   p_q, s2_q, s3_q;
   logic [BF_MAX_W-1:0] p_x, s2_x, s3_x, f_x;
   logic [DATA_W-1:0]   f3;
   logic                unused_hi;

   // A stage loads when it is empty or its successor moves on, so bubbles are squeezed out.
   assign stall      = out_valid && !out_ready;
   assign en2        = !v2 || !stall;
   assign en1        = !v1 || en2;
   assign in_ready   = !sb_we && en1;
   assign accept     = in_valid && in_ready;
   assign pipe_empty = !(v1 || v2 || out_valid);

   always_comb begin
      we_vec = '0;
      case (sb_sel)
         SB_S0:   we_vec[0] = sb_we;
         SB_S1:   we_vec[1] = sb_we;
         SB_S2:   we_vec[2] = sb_we;
         SB_S3:   we_vec[3] = sb_we;
         default: we_vec = '0;
      endcase
   end

   // S-box i is indexed by the i-th IDX_W slice counted from the MSB end.
   for (genvar i = 0; i < NUM_SBOX; i++) begin : g_sbox
      bf_sbox_ram #(
         .IDX_W  (IDX_W),
         .DATA_W (DATA_W)
      ) u_sbox (
         .clk   (clk),
         .we    (we_vec[i]),
         .waddr (sb_addr),
         .wdata (sb_wdata),
         .re    (accept),
         .raddr (in_data[(NUM_SBOX-i)*IDX_W-1 -: IDX_W]),
         .rdata (rd[i])
      );
   end

   always_comb begin
      p_x  = '0;
      s2_x = '0;
      s3_x = '0;
      p_x[DATA_W-1:0]  = p_q;
      s2_x[DATA_W-1:0] = s2_q;
      s3_x[DATA_W-1:0] = s3_q;
      f_x       = bf_f_comb(p_x, '0, s2_x, s3_x);
      f3        = f_x[DATA_W-1:0];
      unused_hi = |f_x[BF_MAX_W-1:DATA_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         p_q       <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (en1) v1 <= accept;
         if (en2) begin
            v2 <= v1;
            if (v1) begin
               p_q  <= rd[0] + rd[1];
               s2_q <= rd[2];
               s3_q <= rd[3];
            end
         end
         if (!stall) begin
            out_valid <= v2;
            if (v2) out_data <= f3;
         end
      end
   end

endmodule

// File: tb/tb_bf_f_pipe.sv
// tb/tb_bf_f_pipe.sv - scoreboard bench for bf_f_pipe against a bf_f_comb reference model
module tb_bf_f_pipe;
   import bf_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        sb_we;
   logic [1:0]  sb_sel;
   logic [7:0]  sb_addr;
   logic [31:0] sb_wdata;
   logic        pipe_empty;

   always #5 clk = ~clk;

   bf_f_pipe #(.IDX_W(8), .DATA_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .sb_we      (sb_we),
      .sb_sel     (sb_sel),
      .sb_addr    (sb_addr),
      .sb_wdata   (sb_wdata),
      .pipe_empty (pipe_empty)
   );

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mdl [4][256];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          n_acc = 0;
   int          n_out = 0;
   logic        stall_prev = 1'b0;
   logic [31:0] held;
   logic [31:0] last_out;

   function automatic logic [31:0] model_f(input logic [31:0] x);
      logic [63:0] r;
      r = bf_f_comb({32'h0, mdl[0][x[31:24]]}, {32'h0, mdl[1][x[23:16]]},
                    {32'h0, mdl[2][x[15:8]]},  {32'h0, mdl[3][x[7:0]]});
      return r[31:0];
   endfunction

   // One clock: sample away from the edge, score outputs, record accepts and writes, advance.
   task automatic step();
      exp_t e;
      #1;
      if (sb_we) begin
         checks++;
         if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL in_ready_during_write: got %b want 0", in_ready);
         end
      end
      if (stall_prev) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== held) begin
            failures++;
            $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, held);
         end
      end
      if (out_valid && out_ready) begin
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output: got %h want none", out_data);
         end else begin
            e = sbq.pop_front();
            if (out_data !== e.data || (cyc - e.cyc) < 3) begin
               failures++;
               $display("FAIL scoreboard: got %h (lat %0d) want %h (lat>=3)", out_data, cyc - e.cyc, e.data);
            end
         end
         last_out = out_data;
         n_out++;
      end
      if (in_valid && in_ready) begin
         sbq.push_back('{data: model_f(in_data), cyc: cyc});
         n_acc++;
      end
      if (sb_we) mdl[sb_sel][sb_addr] = sb_wdata;
      stall_prev = out_valid && !out_ready;
      held = out_data;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic write_sb(input logic [1:0] sel, input logic [7:0] addr, input logic [31:0] data);
      sb_we = 1'b1; sb_sel = sel; sb_addr = addr; sb_wdata = data;
      step();
      sb_we = 1'b0;
   endtask

   task automatic wait_out(input int target, input string name);
      for (int i = 0; i < 30 && n_out < target; i++) step();
      checks++;
      if (n_out < target) begin
         failures++;
         $display("FAIL %s_timeout: got %0d outputs want %0d", name, n_out, target);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      sb_we = 1'b0; sb_sel = '0; sb_addr = '0; sb_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checks += 4;
      if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      if (out_data !== 32'h0)  begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      if (pipe_empty !== 1'b1) begin failures++; $display("FAIL reset_pipe_empty: got %b want 1", pipe_empty); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_load_all();
      for (int s = 0; s < 4; s++)
         for (int a = 0; a < 256; a++)
            write_sb(2'(s), 8'(a), $urandom);
   endtask

   task automatic test_basic();
      int a0;
      write_sb(SB_S0, 8'h12, 32'h0000_0001);
      write_sb(SB_S1, 8'h34, 32'h0000_0002);
      write_sb(SB_S2, 8'h56, 32'h0000_000F);
      write_sb(SB_S3, 8'h78, 32'h1000_0000);
      a0 = n_acc;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678;
      step();
      in_valid = 1'b0;
      checks += 3;
      if (n_acc != a0 + 1)     begin failures++; $display("FAIL basic_accept: got %0d want %0d", n_acc - a0, 1); end
      if (out_valid !== 1'b0)  begin failures++; $display("FAIL basic_lat1: got %b want 0", out_valid); end
      if (pipe_empty !== 1'b0) begin failures++; $display("FAIL basic_busy: got %b want 0", pipe_empty); end
      step();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_lat2: got %b want 0", out_valid); end
      step();
      checks += 2;
      if (out_valid !== 1'b1)         begin failures++; $display("FAIL basic_lat3: got %b want 1", out_valid); end
      if (out_data !== 32'h1000_000C) begin failures++; $display("FAIL basic_data: got %h want 1000000c", out_data); end
      step();
      checks++;
      if (pipe_empty !== 1'b1) begin failures++; $display("FAIL basic_empty: got %b want 1", pipe_empty); end
   endtask

   task automatic test_wrap();
      int o0;
      write_sb(SB_S0, 8'h00, 32'hFFFF_FFFF);
      write_sb(SB_S1, 8'h00, 32'h0000_0002);
      write_sb(SB_S2, 8'h00, 32'h0000_0000);
      write_sb(SB_S3, 8'h00, 32'hFFFF_FFFF);
      o0 = n_out;
      in_valid = 1'b1; in_data = 32'h0;
      step();
      in_valid = 1'b0;
      wait_out(o0 + 1, "wrap");
      checks++;
      if (last_out !== 32'h0) begin failures++; $display("FAIL wrap_data: got %h want 0", last_out); end
   endtask

   task automatic test_backpressure();
      int a0, o0;
      a0 = n_acc; o0 = n_out;
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = $urandom;
         step();
      end
      checks += 2;
      if (n_acc - a0 != 3)    begin failures++; $display("FAIL bp_capacity: got %0d want 3", n_acc - a0); end
      if (in_ready !== 1'b0)  begin failures++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_accept: got %b want 1", in_ready); end
      for (int i = 0; i < 10 && n_acc - a0 < 5; i++) begin
         in_data = $urandom;
         step();
      end
      in_valid = 1'b0;
      wait_out(o0 + 5, "bp");
      checks++;
      if (n_out - o0 != 5) begin failures++; $display("FAIL bp_count: got %0d want 5", n_out - o0); end
   endtask

   task automatic test_write_order();
      int o0;
      o0 = n_out;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678;
      step();
      in_valid = 1'b0;
      step();
      in_valid = 1'b1;
      sb_we = 1'b1; sb_sel = SB_S3; sb_addr = 8'h78; sb_wdata = 32'hA5A5_A5A5;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL wo_in_ready: got %b want 0", in_ready); end
      step();
      sb_we = 1'b0;
      step();
      in_valid = 1'b0;
      wait_out(o0 + 1, "wo_first");
      checks++;
      if (last_out !== 32'h1000_000C) begin failures++; $display("FAIL wo_old_value: got %h want 1000000c", last_out); end
      wait_out(o0 + 2, "wo_second");
      checks++;
      if (last_out !== 32'hA5A5_A5B1) begin failures++; $display("FAIL wo_new_value: got %h want a5a5a5b1", last_out); end
   endtask

   task automatic test_reset_mid();
      int o0, a0;
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = $urandom;
         step();
      end
      checks++;
      if (pipe_empty !== 1'b0) begin failures++; $display("FAIL rm_loaded: got %b want 0", pipe_empty); end
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (out_valid !== 1'b0)  begin failures++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
      if (pipe_empty !== 1'b1) begin failures++; $display("FAIL rm_pipe_empty: got %b want 1", pipe_empty); end
      if (in_ready !== 1'b1)   begin failures++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
      sbq.delete();
      stall_prev = 1'b0;
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1; out_ready = 1'b1;
      o0 = n_out;
      repeat (6) step();
      checks++;
      if (n_out != o0) begin failures++; $display("FAIL rm_stale: got %0d outputs want 0", n_out - o0); end
      a0 = n_acc;
      in_valid = 1'b1; in_data = $urandom;
      step();
      in_valid = 1'b0;
      step();
      step();
      checks += 2;
      if (n_acc != a0 + 1)    begin failures++; $display("FAIL rm_accept: got %0d want 1", n_acc - a0); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL rm_latency: got %b want 1", out_valid); end
      step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 10000; i++) begin
         sb_we = ($urandom_range(15) == 0);
         sb_sel = 2'($urandom_range(3));
         sb_addr = 8'($urandom);
         sb_wdata = $urandom;
         in_valid = ($urandom_range(3) != 0);
         in_data = $urandom;
         out_ready = 1'($urandom_range(1));
         step();
      end
      sb_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
      step();
      checks += 2;
      if (sbq.size() != 0)     begin failures++; $display("FAIL rnd_drain: got %0d pending want 0", sbq.size()); end
      if (pipe_empty !== 1'b1) begin failures++; $display("FAIL rnd_empty: got %b want 1", pipe_empty); end
   endtask

   initial begin
      test_reset();
      test_load_all();
      test_basic();
      test_wrap();
      test_backpressure();
      test_write_order();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
